// File: rtl/gfcm_sel_ctrl.sv
// gfcm_sel_ctrl: break-before-make select sequencer for the glitch-free clock mux.
// Optional macro GFCM_SEL_CTRL_ACK_EN adds clk_on acknowledge gating and a timeout.
module gfcm_sel_ctrl #(
  parameter int unsigned NUMCLK  = 2,
  parameter int unsigned IDXW    = 3,
  parameter int unsigned RST_IDX = 0,
  parameter int unsigned OFF_CYC = 8,
  parameter int unsigned ON_CYC  = 8
`ifdef GFCM_SEL_CTRL_ACK_EN
  ,
  parameter int unsigned TMO_CYC = 1023
`endif
) (
  input  logic              clkin,
  input  logic              rst,
`ifdef GFCM_SEL_CTRL_ACK_EN
  input  logic [NUMCLK-1:0] clk_on,
`endif
  input  logic              req_vld,
  input  logic [IDXW-1:0]   req_idx,
  output logic              req_rdy,
  output logic [NUMCLK-1:0] sel,
  output logic [IDXW-1:0]   cur_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Parameter legality
  if (NUMCLK < 2 || NUMCLK > 8) begin : g_bad_numclk
    $error("gfcm_sel_ctrl: NUMCLK must be 2..8");
  end
  if ((2 ** IDXW) < NUMCLK) begin : g_bad_idxw
    $error("gfcm_sel_ctrl: IDXW too narrow for NUMCLK");
  end
  if (RST_IDX >= NUMCLK) begin : g_bad_rst_idx
    $error("gfcm_sel_ctrl: RST_IDX must be below NUMCLK");
  end
  if (OFF_CYC < 1 || OFF_CYC > 255) begin : g_bad_off
    $error("gfcm_sel_ctrl: OFF_CYC must be 1..255");
  end
  if (ON_CYC < 1 || ON_CYC > 255) begin : g_bad_on
    $error("gfcm_sel_ctrl: ON_CYC must be 1..255");
  end
`ifdef GFCM_SEL_CTRL_ACK_EN
  if (TMO_CYC < 1 || TMO_CYC > 1023) begin : g_bad_tmo
    $error("gfcm_sel_ctrl: TMO_CYC must be 1..1023");
  end
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_OFF,
    S_ON,
    S_DONE
  } state_t;

  localparam logic [IDXW-1:0] RST_I  = IDXW'(RST_IDX);
  localparam logic [7:0]      OFF_LD = 8'(OFF_CYC - 1);
  localparam logic [7:0]      ON_LD  = 8'(ON_CYC - 1);

  function automatic logic [NUMCLK-1:0] onehot(input logic [IDXW-1:0] idx);
    logic [NUMCLK-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NUMCLK; i++) begin
      if (32'(idx) == i) v[i] = 1'b1;
    end
    return v;
  endfunction

  state_t            state, state_nx;
  logic [7:0]        cnt, cnt_nx;
  logic [NUMCLK-1:0] sel_nx;
  logic [IDXW-1:0]   cur_nx;
  logic [IDXW-1:0]   tgt_idx, tgt_nx;
  logic              err_nx;
  logic              idx_bad;
  logic              off_ok;
  logic              on_ok;

`ifdef GFCM_SEL_CTRL_ACK_EN
  logic [NUMCLK-1:0] on_m, on_s;
  logic [9:0]        tmo, tmo_nx;
  logic [IDXW-1:0]   prv_idx, prv_nx;
  logic              tmo_hit;

  // Two-flop resync of per-source gate status
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      on_m <= '0;
      on_s <= '0;
    end else begin
      on_m <= clk_on;
      on_s <= on_m;
    end
  end

  assign off_ok  = (on_s == '0);
  assign on_ok   = ((on_s & onehot(tgt_idx)) != '0);
  assign tmo_hit = (tmo == 10'(TMO_CYC - 1));
`else
  assign off_ok = 1'b1;
  assign on_ok  = 1'b1;
`endif

  assign idx_bad = (32'(req_idx) >= NUMCLK);
  assign req_rdy = (state == S_IDLE);
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);

  // State and datapath registers
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      sel     <= onehot(RST_I);
      cur_idx <= RST_I;
      tgt_idx <= '0;
      err     <= 1'b0;
`ifdef GFCM_SEL_CTRL_ACK_EN
      tmo     <= '0;
      prv_idx <= RST_I;
`endif
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      sel     <= sel_nx;
      cur_idx <= cur_nx;
      tgt_idx <= tgt_nx;
      err     <= err_nx;
`ifdef GFCM_SEL_CTRL_ACK_EN
      tmo     <= tmo_nx;
      prv_idx <= prv_nx;
`endif
    end
  end

  // Next-state and next-register values
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sel_nx   = sel;
    cur_nx   = cur_idx;
    tgt_nx   = tgt_idx;
    err_nx   = 1'b0;
`ifdef GFCM_SEL_CTRL_ACK_EN
    tmo_nx   = tmo;
    prv_nx   = prv_idx;
`endif
    unique case (state)
      S_IDLE: begin
        if (req_vld) begin
          tgt_nx = req_idx;
          if (idx_bad) begin
            err_nx = 1'b1;
          end else if (req_idx == cur_idx) begin
            state_nx = S_DONE;
          end else begin
            state_nx = S_OFF;
            sel_nx   = '0;
            cnt_nx   = OFF_LD;
`ifdef GFCM_SEL_CTRL_ACK_EN
            prv_nx   = cur_idx;
            tmo_nx   = '0;
`endif
          end
        end
      end
      S_OFF: begin
        if (cnt == 8'd0 && off_ok) begin
          state_nx = S_ON;
          sel_nx   = onehot(tgt_idx);
          cur_nx   = tgt_idx;
          cnt_nx   = ON_LD;
`ifdef GFCM_SEL_CTRL_ACK_EN
          tmo_nx   = '0;
        end else if (tmo_hit) begin
          state_nx = S_IDLE;
          sel_nx   = onehot(prv_idx);
          cur_nx   = prv_idx;
          cnt_nx   = '0;
          tmo_nx   = '0;
          err_nx   = 1'b1;
`endif
        end else begin
          // count holds at zero while waiting on the acknowledge
          if (cnt != 8'd0) cnt_nx = cnt - 8'd1;
`ifdef GFCM_SEL_CTRL_ACK_EN
          tmo_nx = tmo + 10'd1;
`endif
        end
      end
      S_ON: begin
        if (cnt == 8'd0 && on_ok) begin
          state_nx = S_DONE;
          cnt_nx   = '0;
`ifdef GFCM_SEL_CTRL_ACK_EN
          tmo_nx   = '0;
        end else if (tmo_hit) begin
          state_nx = S_IDLE;
          sel_nx   = onehot(prv_idx);
          cur_nx   = prv_idx;
          cnt_nx   = '0;
          tmo_nx   = '0;
          err_nx   = 1'b1;
`endif
        end else begin
          if (cnt != 8'd0) cnt_nx = cnt - 8'd1;
`ifdef GFCM_SEL_CTRL_ACK_EN
          tmo_nx = tmo + 10'd1;
`endif
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_gfcm_sel_ctrl.sv
// tb_gfcm_sel_ctrl: directed bench for gfcm_sel_ctrl (NUMCLK=2, RST_IDX=0, OFF/ON=8).
module tb_gfcm_sel_ctrl;

  localparam int unsigned NUMCLK = 2;
  localparam int unsigned IDXW   = 3;

  logic              clkin   = 1'b0;
  logic              rst     = 1'b1;
  logic              req_vld = 1'b0;
  logic [IDXW-1:0]   req_idx = '0;
  logic              req_rdy;
  logic [NUMCLK-1:0] sel;
  logic [IDXW-1:0]   cur_idx;
  logic              busy;
  logic              done;
  logic              err;

  int unsigned n_tot  = 0;
  int unsigned n_pass = 0;
  int unsigned n_fail = 0;
  int unsigned n_done = 0;
  int unsigned n_err  = 0;
  int unsigned saved_done;
  int unsigned saved_err;
  logic [NUMCLK-1:0] prev_sel = '0;

`ifdef GFCM_SEL_CTRL_ACK_EN
  logic              gate_dead = 1'b0;
  logic [NUMCLK-1:0] clk_on_q  = '0;
  logic [NUMCLK-1:0] clk_on;

  // Mux model: gate status follows sel one cycle later unless forced dead
  always @(posedge clkin) clk_on_q <= sel;
  assign clk_on = gate_dead ? '0 : clk_on_q;
`endif

  gfcm_sel_ctrl #(
    .NUMCLK (NUMCLK),
    .IDXW   (IDXW),
    .RST_IDX(0),
    .OFF_CYC(8),
    .ON_CYC (8)
  ) dut (
    .clkin  (clkin),
    .rst    (rst),
`ifdef GFCM_SEL_CTRL_ACK_EN
    .clk_on (clk_on),
`endif
    .req_vld(req_vld),
    .req_idx(req_idx),
    .req_rdy(req_rdy),
    .sel    (sel),
    .cur_idx(cur_idx),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clkin = ~clkin;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clkin);
    @(negedge clkin);
  endtask

  // sel invariants every cycle, plus done/err pulse counting
  always @(negedge clkin) begin
    check("sel_onehot0", 32'($onehot0(sel)), 32'd1);
`ifndef GFCM_SEL_CTRL_ACK_EN
    if (prev_sel != '0 && sel != '0) check("sel_no_direct_swap", 32'(sel), 32'(prev_sel));
`endif
    prev_sel = sel;
    if (done === 1'b1) n_done++;
    if (err === 1'b1) n_err++;
  end

  initial begin
    // Reset held high
    @(negedge clkin);
    check("rst_sel", 32'(sel), 32'h1);
    check("rst_cur", 32'(cur_idx), 32'h0);
    check("rst_rdy", 32'(req_rdy), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_sel", 32'(sel), 32'h1);
    check("post_rst_rdy", 32'(req_rdy), 32'h1);
    check("post_rst_busy", 32'(busy), 32'h0);

    // Switch 0 -> 1, accept at edge T
    req_vld = 1'b1;
    req_idx = 3'd1;
    step();
    req_vld = 1'b0;
    check("sw01_busy", 32'(busy), 32'h1);
    check("sw01_rdy", 32'(req_rdy), 32'h0);
    for (int i = 1; i <= 8; i++) begin
      check("sw01_off_sel", 32'(sel), 32'h0);
      check("sw01_off_done", 32'(done), 32'h0);
      step();
    end
    for (int i = 9; i <= 16; i++) begin
      check("sw01_on_sel", 32'(sel), 32'h2);
      check("sw01_on_cur", 32'(cur_idx), 32'h1);
      check("sw01_on_done", 32'(done), 32'h0);
      step();
    end
    check("sw01_done", 32'(done), 32'h1);
    check("sw01_done_busy", 32'(busy), 32'h1);
    check("sw01_done_rdy", 32'(req_rdy), 32'h0);
    step();
    check("sw01_after_done", 32'(done), 32'h0);
    check("sw01_after_rdy", 32'(req_rdy), 32'h1);
    check("sw01_after_busy", 32'(busy), 32'h0);
    check("sw01_after_cur", 32'(cur_idx), 32'h1);

    // Same-index request
    req_vld = 1'b1;
    req_idx = 3'd1;
    step();
    req_vld = 1'b0;
    check("same_done", 32'(done), 32'h1);
    check("same_busy", 32'(busy), 32'h1);
    check("same_sel", 32'(sel), 32'h2);
    step();
    check("same_done_clr", 32'(done), 32'h0);
    check("same_busy_clr", 32'(busy), 32'h0);
    check("same_sel_hold", 32'(sel), 32'h2);

    // Invalid index
    saved_done = n_done;
    req_vld = 1'b1;
    req_idx = 3'd5;
    step();
    req_vld = 1'b0;
    check("bad_err", 32'(err), 32'h1);
    check("bad_done", 32'(done), 32'h0);
    check("bad_sel", 32'(sel), 32'h2);
    check("bad_cur", 32'(cur_idx), 32'h1);
    check("bad_busy", 32'(busy), 32'h0);
    step();
    check("bad_err_clr", 32'(err), 32'h0);
    check("bad_no_done", n_done, saved_done);

    // Switch 1 -> 0 with req_vld held and req_idx changed while busy
    req_vld = 1'b1;
    req_idx = 3'd0;
    step();
    req_idx = 3'd1;
    for (int i = 1; i <= 8; i++) step();
    check("hold_on_sel", 32'(sel), 32'h1);
    check("hold_on_cur", 32'(cur_idx), 32'h0);
    for (int i = 9; i <= 16; i++) step();
    check("hold_done", 32'(done), 32'h1);
    step();
    check("b2b_rdy", 32'(req_rdy), 32'h1);
    check("b2b_sel", 32'(sel), 32'h1);
    check("b2b_done_clr", 32'(done), 32'h0);

    // Back-to-back accept of 0 -> 1, then reset during OFF
    step();
    req_vld = 1'b0;
    check("b2b_off_sel", 32'(sel), 32'h0);
    check("b2b_off_busy", 32'(busy), 32'h1);
    step();
    step();
    step();
    check("mid_off_sel", 32'(sel), 32'h0);
    saved_done = n_done;
    saved_err  = n_err;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_sel", 32'(sel), 32'h1);
    check("async_rst_cur", 32'(cur_idx), 32'h0);
    check("async_rst_rdy", 32'(req_rdy), 32'h1);
    check("async_rst_busy", 32'(busy), 32'h0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check("rst_lost_no_done", n_done, saved_done);
    check("rst_lost_no_err", n_err, saved_err);
    check("rst_lost_sel", 32'(sel), 32'h1);
    check("rst_lost_busy", 32'(busy), 32'h0);

`ifdef GFCM_SEL_CTRL_ACK_EN
    // Source 1 never acknowledges: timeout restores select 0
    gate_dead = 1'b1;
    saved_done = n_done;
    req_vld = 1'b1;
    req_idx = 3'd1;
    step();
    req_vld = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (err === 1'b1) break;
      step();
    end
    check("tmo_err", 32'(err), 32'h1);
    check("tmo_sel", 32'(sel), 32'h1);
    check("tmo_cur", 32'(cur_idx), 32'h0);
    check("tmo_busy", 32'(busy), 32'h0);
    check("tmo_no_done", n_done, saved_done);
    gate_dead = 1'b0;
`endif

    step();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
